vlc_code_merger: RTL and testbench

Parametrised VLC code output stage that succeeds the single-channel DC output register. Each cycle it accepts up to NUM_CH variable-length codes (for example DC, AC run and AC level), each given as SUM/LENGTH. It concatenates the enabled codes in channel order into one (val, size_of_bit) word and buffers that word in a DEPTH-entry FIFO. The FIFO presents entries to the bit packer with a valid/ready handshake and carries a flush marker through in order.

---
 rtl/vlc_code_merger.sv | 128 ++++++++++++
 tb/tb_vlc_code_merger.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vlc_code_merger.sv
// vlc_code_merger: concatenates up to NUM_CH variable-length codes per cycle into one
// (val, size_of_bit) word and buffers it, with a flush marker, in a DEPTH-entry FIFO.
module vlc_code_merger #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned CODE_W = 32,
    parameter int unsigned OUT_W  = 64,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         enable,
    input  logic [NUM_CH*32-1:0]      LENGTH,
    input  logic [NUM_CH*CODE_W-1:0]  SUM,
    input  logic                      flush,
    output logic                      in_ready,
    input  logic                      out_ready,
    output logic                      output_enable,
    output logic [OUT_W-1:0]          val,
    output logic [OUT_W-1:0]          size_of_bit,
    output logic                      flush_bit,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic                      length_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [31:0] CODE_W_LEN = 32'(CODE_W);
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    logic [31:0]       eff_len [NUM_CH];
    logic              len_bad;
    logic              beat;
    logic [OUT_W-1:0]  acc;
    logic [OUT_W-1:0]  tot;
    logic              write_en;
    logic              pop;

    logic [OUT_W-1:0]  mem_val  [DEPTH];
    logic [OUT_W-1:0]  mem_size [DEPTH];
    logic [DEPTH-1:0]  mem_flush;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Per-channel length clamp; disabled channels contribute nothing.
    always_comb begin
        len_bad = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            eff_len[i] = 32'd0;
            if (enable[i]) begin
                if (LENGTH[i*32 +: 32] > CODE_W_LEN) begin
                    eff_len[i] = CODE_W_LEN;
                    len_bad    = 1'b1;
                end else begin
                    eff_len[i] = LENGTH[i*32 +: 32];
                end
            end
        end
    end

    // Merge codes in channel order; channel 0 ends up most significant.
    always_comb begin
        acc = '0;
        tot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // Shifting all-ones by the full width yields zero, so the mask covers eff_len = OUT_W.
            acc = (acc << eff_len[i])
                | (OUT_W'(SUM[i*CODE_W +: CODE_W]) & ~({OUT_W{1'b1}} << eff_len[i]));
            tot = tot + OUT_W'(eff_len[i]);
        end
    end

    // Handshake decode; in_ready looks only at level so a full FIFO rejects even while popping.
    always_comb begin
        beat          = (|enable) | flush;
        in_ready      = (level != FULL_LEVEL);
        output_enable = (level != '0);
        write_en      = beat & in_ready;
        pop           = output_enable & out_ready;
    end

    // Head entry presented downstream; zeros while empty.
    always_comb begin
        val         = '0;
        size_of_bit = '0;
        flush_bit   = 1'b0;
        if (output_enable) begin
            val         = mem_val[rd_ptr];
            size_of_bit = mem_size[rd_ptr];
            flush_bit   = mem_flush[rd_ptr];
        end
    end

    // FIFO storage; contents need no reset because level gates every read.
    always_ff @(posedge clock) begin
        if (write_en) begin
            mem_val[wr_ptr]   <= acc;
            mem_size[wr_ptr]  <= tot;
            mem_flush[wr_ptr] <= flush;
        end
    end

    // Pointers, occupancy and sticky error flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            length_err <= 1'b0;
        end else begin
            if (write_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({write_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            overflow   <= overflow | (beat & ~in_ready);
            length_err <= length_err | len_bad;
        end
    end

endmodule

// File: tb/tb_vlc_code_merger.sv
// Directed self-checking bench for vlc_code_merger (default parameters).
module tb_vlc_code_merger;

    logic        clock;
    logic        reset_n;
    logic [1:0]  enable;
    logic [63:0] LENGTH;
    logic [63:0] SUM;
    logic        flush;
    logic        in_ready;
    logic        out_ready;
    logic        output_enable;
    logic [63:0] val;
    logic [63:0] size_of_bit;
    logic        flush_bit;
    logic [2:0]  level;
    logic        overflow;
    logic        length_err;

    int n_checks;
    int n_fail;

    vlc_code_merger #(
        .NUM_CH (2),
        .CODE_W (32),
        .OUT_W  (64),
        .DEPTH  (4)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .LENGTH        (LENGTH),
        .SUM           (SUM),
        .flush         (flush),
        .in_ready      (in_ready),
        .out_ready     (out_ready),
        .output_enable (output_enable),
        .val           (val),
        .size_of_bit   (size_of_bit),
        .flush_bit     (flush_bit),
        .level         (level),
        .overflow      (overflow),
        .length_err    (length_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] en, input logic [31:0] l0, input logic [31:0] s0,
                         input logic [31:0] l1, input logic [31:0] s1, input logic fl);
        enable = en;
        LENGTH = {l1, l0};
        SUM    = {s1, s0};
        flush  = fl;
    endtask

    task automatic idle();
        drive(2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        out_ready = 1'b0;
        idle();

        // Reset state
        #2;
        check("rst_oe", 64'(output_enable), 64'd0);
        check("rst_val", val, 64'd0);
        check("rst_size", size_of_bit, 64'd0);
        check("rst_flush", 64'(flush_bit), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_length_err", 64'(length_err), 64'd0);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        step();

        // Single DC passthrough; disabled ch1 with oversize length must not flag
        drive(2'b01, 32'd5, 32'h13, 32'd40, 32'hFFFF_FFFF, 1'b0);
        step();
        idle();
        check("dc_oe", 64'(output_enable), 64'd1);
        check("dc_val", val, 64'h13);
        check("dc_size", size_of_bit, 64'd5);
        check("dc_flush", 64'(flush_bit), 64'd0);
        check("dc_level", 64'(level), 64'd1);
        check("dc_no_len_err", 64'(length_err), 64'd0);
        step();
        check("dc_drain_oe", 64'(output_enable), 64'd0);
        check("dc_drain_val", val, 64'd0);
        check("dc_drain_size", size_of_bit, 64'd0);

        // Two-channel merge, ch1-only, and clamp
        drive(2'b11, 32'd3, 32'h5, 32'd4, 32'hFA, 1'b0);
        step();
        check("merge_val", val, 64'h5A);
        check("merge_size", size_of_bit, 64'd7);
        check("merge_len_err", 64'(length_err), 64'd0);
        drive(2'b10, 32'd3, 32'h5, 32'd8, 32'h1AB, 1'b0);
        step();
        check("ch1_val", val, 64'hAB);
        check("ch1_size", size_of_bit, 64'd8);
        drive(2'b11, 32'd3, 32'h5, 32'd40, 32'hDEAD_BEEF, 1'b0);
        step();
        idle();
        check("clamp_val", val, 64'h5_DEAD_BEEF);
        check("clamp_size", size_of_bit, 64'd35);
        check("clamp_len_err", 64'(length_err), 64'd1);
        step();
        check("clamp_drain_oe", 64'(output_enable), 64'd0);

        // Sustained throughput through pointer wrap
        for (int k = 0; k < 12; k++) begin
            drive(2'b01, 32'd8, 32'(k), 32'd0, 32'd0, 1'b0);
            step();
            check("thru_oe", 64'(output_enable), 64'd1);
            check("thru_val", val, 64'(k));
            check("thru_level", 64'(level), 64'd1);
        end
        idle();
        step();
        check("thru_empty", 64'(level), 64'd0);
        check("thru_no_overflow", 64'(overflow), 64'd0);

        // Backpressure, overflow, and full-with-pop rejection
        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            drive(2'b01, 32'd8, 32'(k), 32'd0, 32'd0, 1'b0);
            step();
            if (k <= 4) check("bp_level", 64'(level), 64'(k));
            check("bp_in_ready", 64'(in_ready), (k < 4) ? 64'd1 : 64'd0);
            if (k == 4) check("bp_no_overflow_yet", 64'(overflow), 64'd0);
        end
        check("bp_level_full", 64'(level), 64'd4);
        check("bp_overflow", 64'(overflow), 64'd1);
        idle();
        step();
        check("bp_hold_val", val, 64'd1);
        check("bp_hold_level", 64'(level), 64'd4);
        out_ready = 1'b1;
        drive(2'b01, 32'd8, 32'h99, 32'd0, 32'd0, 1'b0);
        step();
        idle();
        check("full_pop_level", 64'(level), 64'd3);
        for (int j = 2; j <= 4; j++) begin
            check("bp_order_val", val, 64'(j));
            step();
        end
        check("bp_drain_oe", 64'(output_enable), 64'd0);
        check("bp_drain_val", val, 64'd0);

        // Flush marker behind a code
        out_ready = 1'b0;
        drive(2'b01, 32'd4, 32'hC, 32'd0, 32'd0, 1'b0);
        step();
        drive(2'b00, 32'd7, 32'h7F, 32'd0, 32'd0, 1'b1);
        step();
        idle();
        check("fl_level", 64'(level), 64'd2);
        check("fl_first_val", val, 64'hC);
        check("fl_first_size", size_of_bit, 64'd4);
        check("fl_first_flush", 64'(flush_bit), 64'd0);
        out_ready = 1'b1;
        step();
        check("fl_oe", 64'(output_enable), 64'd1);
        check("fl_val", val, 64'd0);
        check("fl_size", size_of_bit, 64'd0);
        check("fl_flush", 64'(flush_bit), 64'd1);
        step();
        check("fl_drain_oe", 64'(output_enable), 64'd0);
        check("fl_drain_flush", 64'(flush_bit), 64'd0);

        // Reset mid-operation
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(2'b01, 32'd8, 32'(8'hA0 + k), 32'd0, 32'd0, 1'b0);
            step();
        end
        idle();
        check("mid_level", 64'(level), 64'd3);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_oe", 64'(output_enable), 64'd0);
        check("mid_rst_val", val, 64'd0);
        check("mid_rst_level", 64'(level), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_overflow", 64'(overflow), 64'd0);
        check("mid_rst_length_err", 64'(length_err), 64'd0);
        #1 reset_n = 1'b1;
        drive(2'b01, 32'd8, 32'h42, 32'd0, 32'd0, 1'b0);
        step();
        idle();
        check("post_rst_val", val, 64'h42);
        check("post_rst_size", size_of_bit, 64'd8);
        check("post_rst_level", 64'(level), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
